// File: rtl/cs42448_cfg_seq.sv
// CS42448 power-up and configuration sequencer: drives the codec reset pin, then
// writes every register-table entry through the shared I2C byte-write master.
module cs42448_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h48,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned RST_HOLD_CYC = 1000,
    parameter int unsigned RST_WAIT_CYC = 50000,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned TIMEOUT_CYC  = 200000,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_idx,
    output logic        audio_en,
    output logic        codec_nrst,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_dev,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack
);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_ASSERT, S_RST_WAIT, S_FETCH1, S_FETCH2,
        S_ISSUE, S_WAIT_RSP, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYC - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT_CYC - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  IDX_LAST  = 8'(NUM_REGS - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt;
    logic [7:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_retry, w_retry_nxt;
    logic        r_auto;
    logic        w_hs;

    assign w_hs = cmd_valid & cmd_ready;

    // State and sequence counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_idx   <= 8'd0;
            r_retry <= 4'd0;
            r_auto  <= AUTO_START;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_retry <= w_retry_nxt;
            r_auto  <= 1'b0;
            // One shared cycle counter, restarted on every state change.
            if (w_state_nxt != r_state) begin
                r_cnt <= 32'd0;
            end else if (r_cnt != 32'hFFFF_FFFF) begin
                r_cnt <= r_cnt + 32'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next-state, table index and retry bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_retry_nxt = r_retry;
        case (r_state)
            S_IDLE: begin
                if (start || r_auto) w_state_nxt = S_RST_ASSERT;
                else                 w_state_nxt = S_IDLE;
            end
            S_RST_ASSERT: begin
                if (r_cnt == HOLD_LAST) w_state_nxt = S_RST_WAIT;
                else                    w_state_nxt = S_RST_ASSERT;
            end
            S_RST_WAIT: begin
                w_idx_nxt   = 8'd0;
                w_retry_nxt = 4'd0;
                if (r_cnt == WAIT_LAST) w_state_nxt = S_FETCH1;
                else                    w_state_nxt = S_RST_WAIT;
            end
            S_FETCH1: w_state_nxt = S_FETCH2;
            S_FETCH2: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_hs) w_state_nxt = S_WAIT_RSP;
                else      w_state_nxt = S_ISSUE;
            end
            S_WAIT_RSP: begin
                // A response arriving on the timeout cycle wins over the timeout.
                if (rsp_valid && !rsp_nack) begin
                    w_retry_nxt = 4'd0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = S_FETCH1;
                    end
                end else if (rsp_valid || (r_cnt == TO_LAST)) begin
                    if (r_retry < RETRY_LIM) begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end else begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) w_state_nxt = S_RST_ASSERT;
                else       w_state_nxt = r_state;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            audio_en   <= 1'b0;
            codec_nrst <= 1'b0;
            cmd_valid  <= 1'b0;
            tbl_addr   <= 8'd0;
            err_idx    <= 8'd0;
            cmd_dev    <= 7'd0;
            cmd_reg    <= 8'd0;
            cmd_data   <= 8'd0;
        end else begin
            busy       <= w_state_nxt inside {S_RST_ASSERT, S_RST_WAIT, S_FETCH1,
                                              S_FETCH2, S_ISSUE, S_WAIT_RSP};
            done       <= (w_state_nxt == S_DONE);
            audio_en   <= (w_state_nxt == S_DONE);
            err        <= (w_state_nxt == S_ERROR);
            codec_nrst <= !(w_state_nxt inside {S_IDLE, S_RST_ASSERT});
            cmd_valid  <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_FETCH1) tbl_addr <= w_idx_nxt;
            else                         tbl_addr <= tbl_addr;
            if (r_state == S_FETCH2) begin
                cmd_dev  <= DEV_ADDR;
                cmd_reg  <= tbl_data[15:8];
                cmd_data <= tbl_data[7:0];
            end else begin
                cmd_dev  <= cmd_dev;
                cmd_reg  <= cmd_reg;
                cmd_data <= cmd_data;
            end
            if ((r_state == S_WAIT_RSP) && (w_state_nxt == S_ERROR)) err_idx <= r_idx;
            else                                                    err_idx <= err_idx;
        end
    end

endmodule
